// File: rtl/uart_cmd_ctrl.sv
// UART command controller: pops ASCII command bytes from the RX FIFO, drives
// per-channel run/mode/clear controls and optionally answers each command with
// an ACK/NAK byte into the TX FIFO.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a byte; pops one as soon as the RX FIFO is non-empty
//   DECODE | popped byte is on rx_data; apply command, latch the response byte
//   ACK    | push the response byte; stall here while the TX FIFO is full
module uart_cmd_ctrl #(
    parameter int          NUM_CH      = 3,
    parameter bit          ACK_EN      = 1'b1,
    parameter logic [7:0]  CMD_RUN     = 8'h72,
    parameter logic [7:0]  CMD_STOP    = 8'h73,
    parameter logic [7:0]  CMD_CLR     = 8'h63,
    parameter logic [7:0]  CMD_MODE    = 8'h6D,
    parameter logic [7:0]  CMD_RUNALL  = 8'h52,
    parameter logic [7:0]  CMD_STOPALL = 8'h53,
    parameter logic [7:0]  ACK_BYTE    = 8'h41,
    parameter logic [7:0]  NAK_BYTE    = 8'h4E,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    output logic              rx_rd,
    input  logic [7:0]        rx_data,
    input  logic              tx_full,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    output logic [NUM_CH-1:0] o_run_stop,
    output logic [NUM_CH-1:0] o_mode,
    output logic [NUM_CH-1:0] o_clear,
    output logic [CH_W-1:0]   o_sel_ch
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] clear_q, clear_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        resp;
    logic [7:0]        digit;

    // State and control registers; reset drops any byte popped but not decoded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            run_q     <= '0;
            mode_q    <= '0;
            clear_q   <= '0;
            sel_q     <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            mode_q    <= mode_d;
            clear_q   <= clear_d;
            sel_q     <= sel_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state, command decode and FIFO strobes.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        mode_d    = mode_q;
        clear_d   = '0;
        sel_d     = sel_q;
        tx_data_d = tx_data_q;
        rx_rd     = 1'b0;
        tx_wr     = 1'b0;
        resp      = NAK_BYTE;
        digit     = rx_data - 8'h30;

        case (state_q)
            IDLE: begin
                rx_rd = !rx_empty;
                if (!rx_empty) begin
                    state_d = DECODE;
                end
            end

            DECODE: begin
                resp = ACK_BYTE;
                if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
                    // Digits beyond the channel count are rejected, selection kept.
                    if (digit < 8'(NUM_CH)) begin
                        sel_d = digit[CH_W-1:0];
                    end else begin
                        resp = NAK_BYTE;
                    end
                end else if (rx_data == CMD_RUN) begin
                    run_d[sel_q] = 1'b1;
                end else if (rx_data == CMD_STOP) begin
                    run_d[sel_q] = 1'b0;
                end else if (rx_data == CMD_CLR) begin
                    clear_d[sel_q] = 1'b1;
                    run_d[sel_q]   = 1'b0;
                end else if (rx_data == CMD_MODE) begin
                    mode_d[sel_q] = ~mode_q[sel_q];
                end else if (rx_data == CMD_RUNALL) begin
                    run_d = '1;
                end else if (rx_data == CMD_STOPALL) begin
                    run_d = '0;
                end else begin
                    resp = NAK_BYTE;
                end

                if (ACK_EN) begin
                    tx_data_d = resp;
                    state_d   = ACK;
                end else begin
                    state_d = IDLE;
                end
            end

            ACK: begin
                tx_wr = !tx_full;
                if (!tx_full) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign tx_data    = tx_data_q;
    assign o_run_stop = run_q;
    assign o_mode     = mode_q;
    assign o_clear    = clear_q;
    assign o_sel_ch   = sel_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: an RX FIFO model feeds command bytes, a monitor
// pops expected ACK/NAK bytes from a queue whenever tx_wr fires, and directed
// checks cover control outputs, timing, TX back-pressure, reset and ACK_EN=0.
module tb_uart_cmd_ctrl;

    localparam int NUM_CH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_empty;
    logic        rx_rd;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_full = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic [2:0]  run_stop, mode, clear;
    logic [1:0]  sel_ch;

    logic        rx_empty0 = 1'b1;
    logic        rx_rd0;
    logic [7:0]  rx_data0 = 8'h00;
    logic        tx_wr0;
    logic [7:0]  tx_data0;
    logic [2:0]  run_stop0, mode0, clear0;
    logic [1:0]  sel_ch0;

    int checks   = 0;
    int failures = 0;
    int tx_seen  = 0;
    int tx0_seen = 0;

    logic [7:0] rx_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.NUM_CH(NUM_CH), .ACK_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rx_empty(rx_empty), .rx_rd(rx_rd), .rx_data(rx_data),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
        .o_run_stop(run_stop), .o_mode(mode), .o_clear(clear), .o_sel_ch(sel_ch)
    );

    uart_cmd_ctrl #(.NUM_CH(NUM_CH), .ACK_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .rx_empty(rx_empty0), .rx_rd(rx_rd0), .rx_data(rx_data0),
        .tx_full(tx_full), .tx_wr(tx_wr0), .tx_data(tx_data0),
        .o_run_stop(run_stop0), .o_mode(mode0), .o_clear(clear0), .o_sel_ch(sel_ch0)
    );

    // RX FIFO model: data appears the cycle after the pop strobe.
    assign rx_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (rx_rd) begin
            rx_data <= rx_mem[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // TX monitor / scoreboard.
    always @(negedge clk) begin
        if (tx_wr) begin
            tx_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected: got %02h expected no push", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    failures++;
                    $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
                end
            end
            if (tx_full) begin
                failures++;
                $display("FAIL tx_wr_while_full: got tx_wr=1 expected 0");
            end
        end
        if (tx_wr0) tx0_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input logic [7:0] b, input logic [7:0] resp);
        rx_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
        exp_q.push_back(resp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tx_full = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(rd_ptr == wr_ptr && exp_q.size() == 0) && n < 200) begin
            step();
            n++;
        end
        chk("drain_done", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        step();
    endtask

    // ACK_EN=0 instance: one byte every two cycles, no TX traffic.
    task automatic send0(input logic [7:0] b);
        rx_empty0 = 1'b0;
        #1;
        chk("rd0_strobe", {31'd0, rx_rd0}, 32'd1);
        step();
        rx_empty0 = 1'b1;
        rx_data0  = b;
        step();
    endtask

    localparam logic [7:0] A = 8'h41;
    localparam logic [7:0] N = 8'h4E;

    initial begin
        int clr_cycles;
        int stall_bad;
        int tx_before;
        logic [2:0] clr_val;

        // Reset values.
        step();
        chk("rst_run",   {29'd0, run_stop}, 32'd0);
        chk("rst_mode",  {29'd0, mode},     32'd0);
        chk("rst_clear", {29'd0, clear},    32'd0);
        chk("rst_sel",   {30'd0, sel_ch},   32'd0);
        chk("rst_rx_rd", {31'd0, rx_rd},    32'd0);
        chk("rst_tx_wr", {31'd0, tx_wr},    32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b1;
        step();

        // 'r': pop in cycle 0, decode in cycle 1, visible with tx_wr in cycle 2.
        push_rx(8'h72, A);
        #1;
        chk("r_pop_c0", {31'd0, rx_rd}, 32'd1);
        step();
        chk("r_no_pop_c1", {31'd0, rx_rd}, 32'd0);
        chk("r_run_c1", {29'd0, run_stop}, 32'd0);
        step();
        chk("r_run_c2", {29'd0, run_stop}, 32'b001);
        chk("r_tx_wr_c2", {31'd0, tx_wr}, 32'd1);
        drain();

        // '2','r','1','m'.
        do_reset();
        push_rx("2", A); push_rx("r", A); push_rx("1", A); push_rx("m", A);
        drain();
        chk("seq_sel",  {30'd0, sel_ch},   32'd1);
        chk("seq_run",  {29'd0, run_stop}, 32'b100);
        chk("seq_mode", {29'd0, mode},     32'b010);

        // Out-of-range digit and unknown byte.
        do_reset();
        push_rx("5", N); push_rx("x", N);
        drain();
        chk("nak_sel",  {30'd0, sel_ch},   32'd0);
        chk("nak_run",  {29'd0, run_stop}, 32'd0);
        chk("nak_mode", {29'd0, mode},     32'd0);

        // RUNALL, then clear of channel 1.
        do_reset();
        push_rx("R", A);
        drain();
        chk("runall", {29'd0, run_stop}, 32'b111);
        push_rx("1", A); push_rx("c", A);
        clr_cycles = 0;
        clr_val = 3'b000;
        for (int i = 0; i < 12; i++) begin
            step();
            if (clear != 3'b000) begin
                clr_cycles++;
                clr_val = clear;
            end
        end
        chk("clr_width", clr_cycles, 32'd1);
        chk("clr_value", {29'd0, clr_val}, 32'b010);
        chk("clr_run",   {29'd0, run_stop}, 32'b101);
        chk("clr_sel",   {30'd0, sel_ch},   32'd1);
        drain();

        // TX back-pressure: stall in ACK with no pops, then resume in order.
        do_reset();
        tx_full = 1'b1;
        push_rx("r", A); push_rx("2", A); push_rx("x", N); push_rx("m", A);
        step();
        step();
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rx_rd || tx_wr) stall_bad++;
            step();
        end
        chk("stall_no_strobes", stall_bad, 32'd0);
        chk("stall_run", {29'd0, run_stop}, 32'b001);
        chk("stall_queued", wr_ptr - rd_ptr, 32'd3);
        tx_full = 1'b0;
        drain();
        chk("stall_sel",  {30'd0, sel_ch},   32'd2);
        chk("stall_run2", {29'd0, run_stop}, 32'b001);
        chk("stall_mode", {29'd0, mode},     32'b100);

        // Reset asserted while decoding 'R'.
        do_reset();
        rx_mem[wr_ptr[7:0]] = "R";
        wr_ptr++;
        step();
        rst = 1'b0;
        #1;
        chk("arst_run",   {29'd0, run_stop}, 32'd0);
        chk("arst_clear", {29'd0, clear},    32'd0);
        chk("arst_tx_wr", {31'd0, tx_wr},    32'd0);
        chk("arst_rx_rd", {31'd0, rx_rd},    32'd0);
        tx_before = tx_seen;
        step();
        step();
        rst = 1'b1;
        repeat (6) step();
        chk("arst_no_tx", tx_seen, tx_before);
        chk("arst_run_after", {29'd0, run_stop}, 32'd0);

        // ACK_EN=0 build.
        do_reset();
        send0("r");
        chk("n0_run", {29'd0, run_stop0}, 32'b001);
        send0("1");
        send0("m");
        chk("n0_sel",  {30'd0, sel_ch0}, 32'd1);
        chk("n0_mode", {29'd0, mode0},   32'b010);
        send0("c");
        chk("n0_clear", {29'd0, clear0}, 32'b010);
        step();
        chk("n0_clear_end", {29'd0, clear0}, 32'd0);
        chk("n0_no_tx", tx0_seen, 32'd0);
        chk("exp_left", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
